// File: rtl/meas_filter.sv
// Qualifies ultrasonic echo-width samples, averages the last 2^AVG_LOG2 good ones, and exposes status on the fx bus.
// Define MEAS_FILTER_EN to build the ring-buffer averager; otherwise dist_avg follows each good sample.
module meas_filter #(
  parameter int unsigned AVG_LOG2  = 2,
  parameter logic [15:0] MAX_US    = 16'd23200,
  parameter logic [21:0] BASE_ADDR = 22'h000100
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        done_measure,
  input  logic        err_measure,
  input  logic [15:0] data_measure,
  output logic [15:0] dist_avg,
  output logic        avg_vld,
  input  logic        fx_rd,
  input  logic [21:0] fx_raddr,
  output logic [7:0]  fx_q
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SW    = 16 + AVG_LOG2;
  localparam int unsigned FW    = AVG_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_OUT} state_t;

  state_t      state, nxt_state;
  logic [15:0] smp;
  logic        pend_vld, pend_err;
  logic [15:0] pend_data;
  logic        ovr;
  logic [7:0]  smp_cnt, err_cnt, shadow;

  logic        try_c, try_err_c, bad_c, good_c;
  logic [15:0] try_data_c;
  logic        pop_c, push_c, drop_c;
  logic        full_c, upd_vld_c;
  logic [15:0] upd_val_c;

  // Next state plus sample source selection (live input or pending slot)
  always_comb begin
    nxt_state  = state;
    try_c      = 1'b0;
    try_data_c = data_measure;
    try_err_c  = err_measure;
    pop_c      = 1'b0;
    push_c     = 1'b0;
    drop_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_vld) begin
          try_c      = 1'b1;
          pop_c      = 1'b1;
          try_data_c = pend_data;
          try_err_c  = pend_err;
          push_c     = done_measure;
        end else begin
          try_c = done_measure;
        end
      end
      S_UPD: begin
        nxt_state = S_OUT;
        push_c    = done_measure && !pend_vld;
        drop_c    = done_measure && pend_vld;
      end
      S_OUT: begin
        nxt_state = S_IDLE;
        push_c    = done_measure && !pend_vld;
        drop_c    = done_measure && pend_vld;
        if (pend_vld) begin
          try_c      = 1'b1;
          pop_c      = 1'b1;
          try_data_c = pend_data;
          try_err_c  = pend_err;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
    bad_c  = try_c && (try_err_c || (try_data_c == 16'd0) || (try_data_c > MAX_US));
    good_c = try_c && !bad_c;
    if (good_c) nxt_state = S_UPD;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt_state;
  end

`ifdef MEAS_FILTER_EN
  logic [15:0]         ring [DEPTH];
  logic [SW-1:0]       sum, sum_nxt_c;
  logic [AVG_LOG2-1:0] wp;
  logic [FW-1:0]       fill, fill_nxt_c;

  always_comb begin
    sum_nxt_c  = sum - SW'(ring[wp]) + SW'(smp);
    fill_nxt_c = (fill == FW'(DEPTH)) ? fill : fill + FW'(1);
    full_c     = (fill == FW'(DEPTH));
    upd_vld_c  = (state == S_UPD) && (fill_nxt_c == FW'(DEPTH));
    upd_val_c  = 16'(sum_nxt_c >> AVG_LOG2);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      wp   <= '0;
      fill <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ring[i] <= '0;
    end else if (state == S_UPD) begin
      sum      <= sum_nxt_c;
      ring[wp] <= smp;
      wp       <= wp + AVG_LOG2'(1);
      fill     <= fill_nxt_c;
    end
  end
`else
  logic seen;

  always_comb begin
    full_c    = seen;
    upd_vld_c = (state == S_UPD);
    upd_val_c = smp;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                seen <= 1'b0;
    else if (state == S_UPD)   seen <= 1'b1;
  end
`endif

  logic [21:0] off_c;
  logic [8:0]  err_sum_c;
  logic [7:0]  status_c;

  always_comb begin
    off_c     = fx_raddr - BASE_ADDR;
    err_sum_c = 9'(err_cnt) + 9'(bad_c) + 9'(err_measure && !done_measure);
    status_c  = {5'b0, ovr, full_c, state != S_IDLE};
  end

  // Sample latch, pending slot, counters and output registers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      smp       <= '0;
      pend_vld  <= 1'b0;
      pend_err  <= 1'b0;
      pend_data <= '0;
      ovr       <= 1'b0;
      smp_cnt   <= '0;
      err_cnt   <= '0;
      dist_avg  <= '0;
      avg_vld   <= 1'b0;
    end else begin
      if (good_c) smp <= try_data_c;
      if (push_c) begin
        pend_vld  <= 1'b1;
        pend_data <= data_measure;
        pend_err  <= err_measure;
      end else if (pop_c) begin
        pend_vld <= 1'b0;
      end
      if (fx_rd && off_c == 22'd4) ovr <= 1'b0;
      if (drop_c) ovr <= 1'b1;
      if (state == S_OUT && smp_cnt != 8'hFF) smp_cnt <= smp_cnt + 8'd1;
      err_cnt <= (err_sum_c > 9'h0FF) ? 8'hFF : err_sum_c[7:0];
      avg_vld <= upd_vld_c;
      if (upd_vld_c) dist_avg <= upd_val_c;
    end
  end

  // fx read port; reading the low byte freezes the high byte for a coherent pair
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q   <= '0;
      shadow <= '0;
    end else if (fx_rd) begin
      case (off_c)
        22'd0: begin
          fx_q   <= dist_avg[7:0];
          shadow <= dist_avg[15:8];
        end
        22'd1:   fx_q <= shadow;
        22'd2:   fx_q <= smp_cnt;
        22'd3:   fx_q <= err_cnt;
        22'd4:   fx_q <= status_c;
        default: fx_q <= 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_meas_filter.sv
// Directed bench for meas_filter; expectations follow MEAS_FILTER_EN the same way the design does.
module tb_meas_filter;

  localparam logic [21:0] BASE = 22'h000100;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        done_measure, err_measure;
  logic [15:0] data_measure;
  logic [15:0] dist_avg;
  logic        avg_vld;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int vld_mark;

  meas_filter dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .done_measure (done_measure),
    .err_measure  (err_measure),
    .data_measure (data_measure),
    .dist_avg     (dist_avg),
    .avg_vld      (avg_vld),
    .fx_rd        (fx_rd),
    .fx_raddr     (fx_raddr),
    .fx_q         (fx_q)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (avg_vld === 1'b1) vld_cnt <= vld_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [21:0] a, input logic [7:0] exp);
    @(negedge clk_sys);
    fx_rd = 1'b1; fx_raddr = a;
    @(negedge clk_sys);
    fx_rd = 1'b0; fx_raddr = '0;
    check(tag, 32'(fx_q), 32'(exp));
  endtask

  task automatic sample(input string tag, input logic [15:0] d, input logic e,
                        input logic ev, input logic chk, input logic [15:0] ea);
    @(negedge clk_sys);
    done_measure = 1'b1; data_measure = d; err_measure = e;
    @(negedge clk_sys);
    done_measure = 1'b0; data_measure = '0; err_measure = 1'b0;
    check({tag, "_n1"}, 32'(avg_vld), 32'd0);
    @(negedge clk_sys);
    check({tag, "_vld"}, 32'(avg_vld), 32'(ev));
    if (chk) check({tag, "_avg"}, 32'(dist_avg), 32'(ea));
    @(negedge clk_sys);
  endtask

  initial begin
    rst_n = 1'b0; done_measure = 1'b0; err_measure = 1'b0; data_measure = '0;
    fx_rd = 1'b0; fx_raddr = '0;
    repeat (3) @(negedge clk_sys);
    check("rst_avg", 32'(dist_avg), 32'd0);
    check("rst_vld", 32'(avg_vld), 32'd0);
    check("rst_fxq", 32'(fx_q), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) rd_chk($sformatf("rst_reg%0d", i), BASE + 22'(i), 8'h00);
    check("rst_novld", 32'(vld_cnt), 32'd0);

`ifdef MEAS_FILTER_EN
    sample("s100", 16'd100, 1'b0, 1'b0, 1'b0, 16'd0);
    sample("s200", 16'd200, 1'b0, 1'b0, 1'b0, 16'd0);
    sample("s300", 16'd300, 1'b0, 1'b0, 1'b0, 16'd0);
    sample("s400", 16'd400, 1'b0, 1'b1, 1'b1, 16'd250);
    sample("s500", 16'd500, 1'b0, 1'b1, 1'b1, 16'd350);
    sample("s777", 16'd777, 1'b0, 1'b1, 1'b1, 16'd494);
    check("vld_count1", 32'(vld_cnt), 32'd3);
`else
    sample("s100", 16'd100, 1'b0, 1'b1, 1'b1, 16'd100);
    sample("s200", 16'd200, 1'b0, 1'b1, 1'b1, 16'd200);
    sample("s300", 16'd300, 1'b0, 1'b1, 1'b1, 16'd300);
    sample("s400", 16'd400, 1'b0, 1'b1, 1'b1, 16'd400);
    sample("s500", 16'd500, 1'b0, 1'b1, 1'b1, 16'd500);
    sample("s777", 16'd777, 1'b0, 1'b1, 1'b1, 16'd777);
    check("vld_count1", 32'(vld_cnt), 32'd6);
`endif
    rd_chk("smp_cnt6", BASE + 22'd2, 8'd6);

    // Rejected samples: out of range, errored done, bare error
    vld_mark = vld_cnt;
    sample("big", 16'd30000, 1'b0, 1'b0, 1'b0, 16'd0);
    sample("errdone", 16'd500, 1'b1, 1'b0, 1'b0, 16'd0);
    @(negedge clk_sys); err_measure = 1'b1;
    @(negedge clk_sys); err_measure = 1'b0;
    rd_chk("err_cnt3", BASE + 22'd3, 8'd3);
    rd_chk("smp_cnt_keep", BASE + 22'd2, 8'd6);
    check("err_novld", 32'(vld_cnt), 32'(vld_mark));

    // Back-to-back dones: first runs, second pends, third is dropped
    @(negedge clk_sys); done_measure = 1'b1; data_measure = 16'd1000;
    @(negedge clk_sys); data_measure = 16'd1001;
    @(negedge clk_sys);
    check("b2b_vld1", 32'(avg_vld), 32'd1);
`ifdef MEAS_FILTER_EN
    check("b2b_avg1", 32'(dist_avg), 32'd669);
`else
    check("b2b_avg1", 32'(dist_avg), 32'd1000);
`endif
    data_measure = 16'd1002;
    @(negedge clk_sys); done_measure = 1'b0; data_measure = '0;
    check("b2b_gap", 32'(avg_vld), 32'd0);
    @(negedge clk_sys);
    check("b2b_vld2", 32'(avg_vld), 32'd1);
`ifdef MEAS_FILTER_EN
    check("b2b_avg2", 32'(dist_avg), 32'd819);
`else
    check("b2b_avg2", 32'(dist_avg), 32'd1001);
`endif
    @(negedge clk_sys);
    check("b2b_end", 32'(avg_vld), 32'd0);
    repeat (3) @(negedge clk_sys);
    rd_chk("smp_cnt8", BASE + 22'd2, 8'd8);
    rd_chk("status_ovr", BASE + 22'd4, 8'h06);
    rd_chk("status_clr", BASE + 22'd4, 8'h02);

    // High-byte shadow keeps the 16-bit pair coherent
    for (int i = 0; i < 4; i++) sample("s1234", 16'h1234, 1'b0, 1'b1, 1'b0, 16'd0);
    check("avg_1234", 32'(dist_avg), 32'h1234);
    rd_chk("lo_1234", BASE, 8'h34);
    for (int i = 0; i < 4; i++) sample("s4321", 16'h4321, 1'b0, 1'b1, 1'b0, 16'd0);
    check("avg_4321", 32'(dist_avg), 32'h4321);
    rd_chk("hi_shadow_old", BASE + 22'd1, 8'h12);
    rd_chk("lo_4321", BASE, 8'h21);
    rd_chk("hi_4321", BASE + 22'd1, 8'h43);
    rd_chk("addr_above", BASE + 22'd5, 8'h00);
    rd_chk("addr_below", BASE - 22'd1, 8'h00);
    rd_chk("smp_cnt16", BASE + 22'd2, 8'd16);

    // Reset while an update is in flight discards it entirely
    vld_mark = vld_cnt;
    @(negedge clk_sys); done_measure = 1'b1; data_measure = 16'd777;
    @(negedge clk_sys); done_measure = 1'b0; data_measure = '0; rst_n = 1'b0;
    @(negedge clk_sys);
    check("rstmid_vld", 32'(avg_vld), 32'd0);
    check("rstmid_avg", 32'(dist_avg), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("rstmid_novld", 32'(vld_cnt), 32'(vld_mark));
    for (int i = 0; i < 5; i++) rd_chk($sformatf("rstmid_reg%0d", i), BASE + 22'(i), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
